hbm_rd_sequencer: RTL and testbench

//  Read-traffic sequencer for one HBM pseudo-channel AXI3 master port. On start, issues a

---
 rtl/hbm_rd_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_hbm_rd_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_rd_sequencer.sv
// Read-traffic sequencer for one HBM pseudo-channel AXI3 master: strided AR bursts, R sink, run counters.
// Define HBM_RD_LAT_MON_EN to build the first-beat latency monitor; otherwise lat_first is tied 0.

module hbm_rd_sequencer #(
    parameter int ADDR_WIDTH      = 33,
    parameter int ID_WIDTH        = 6,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [31:0]           cfg_stride,
    input  logic [31:0]           cfg_mask,
    input  logic [31:0]           cfg_num,
    input  logic [3:0]            cfg_len,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [ID_WIDTH-1:0]   arid,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic                  rvalid,
    input  logic                  rlast,
    input  logic [1:0]            rresp,
    output logic                  rready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           beat_cnt,
    output logic [15:0]           err_cnt,
    output logic [47:0]           cycle_cnt,
    output logic [15:0]           lat_first
);

    localparam int            OW      = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           stride_q, mask_q, num_q;
    logic [3:0]            len_q;
    logic [31:0]           issued_q, issued_d;
    logic [31:0]           off_q, off_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic [31:0]           beat_q, beat_d;
    logic [15:0]           err_q, err_d;
    logic [47:0]           cyc_q, cyc_d;
    logic                  rready_q;

    logic start_acc, active, ar_fire, r_fire, r_close;

    assign start_acc = start && (state_q == S_IDLE);
    assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign ar_fire   = arvalid && arready;
    assign r_fire    = rvalid && rready_q;
    // Stray beats outside a run are accepted but never close a burst.
    assign r_close   = active && r_fire && rlast && (outst_q != '0);

    // Issue condition can only drop through a handshake, so AR never withdraws.
    assign arvalid   = (state_q == S_RUN) && (issued_q < num_q) && (outst_q < OUT_MAX);
    assign araddr    = base_q + ADDR_WIDTH'(off_q & mask_q);
    assign arlen     = len_q;
    assign arsize    = 3'b101;
    assign arburst   = 2'b01;
    assign arid      = '0;
    assign rready    = rready_q;
    assign busy      = active;
    assign done      = (state_q == S_DONE);
    assign beat_cnt  = beat_q;
    assign err_cnt   = err_q;
    assign cycle_cnt = cyc_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d  = state_q;
        issued_d = issued_q;
        off_d    = off_q;
        outst_d  = outst_q;
        beat_d   = beat_q;
        err_d    = err_q;
        cyc_d    = cyc_q;

        unique case (state_q)
            S_IDLE: if (start) begin
                state_d  = (cfg_num == 32'd0) ? S_DONE : S_RUN;
                issued_d = '0;
                off_d    = '0;
                outst_d  = '0;
                beat_d   = '0;
                err_d    = '0;
                cyc_d    = '0;
            end
            S_RUN:   if (ar_fire && (issued_q + 32'd1 == num_q)) state_d = S_DRAIN;
            S_DRAIN: if (outst_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (active) begin
            cyc_d = cyc_q + 48'd1;
            if (r_fire) begin
                beat_d = beat_q + 32'd1;
                if ((rresp != 2'b00) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
            end
        end

        if (ar_fire) begin
            issued_d = issued_q + 32'd1;
            off_d    = off_q + stride_q;
        end

        unique case ({ar_fire, r_close})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            off_q    <= '0;
            outst_q  <= '0;
            beat_q   <= '0;
            err_q    <= '0;
            cyc_q    <= '0;
            rready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            off_q    <= off_d;
            outst_q  <= outst_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
            rready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            base_q   <= '0;
            stride_q <= '0;
            mask_q   <= '0;
            num_q    <= '0;
            len_q    <= '0;
        end else if (start_acc) begin
            base_q   <= cfg_base;
            stride_q <= cfg_stride;
            mask_q   <= cfg_mask;
            num_q    <= cfg_num;
            len_q    <= cfg_len;
        end
    end

`ifdef HBM_RD_LAT_MON_EN
    logic        lat_arm_q, lat_hit_q;
    logic [15:0] lat_cnt_q, lat_q;

    // Armed on the first AR handshake; the first R handshake afterwards captures the count.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            lat_arm_q <= 1'b0;
            lat_hit_q <= 1'b0;
            lat_cnt_q <= '0;
            lat_q     <= '0;
        end else if (start_acc) begin
            lat_arm_q <= 1'b0;
            lat_hit_q <= 1'b0;
            lat_cnt_q <= '0;
            lat_q     <= '0;
        end else if (active) begin
            if (lat_arm_q) begin
                if (r_fire) begin
                    lat_q     <= (lat_cnt_q == 16'hFFFF) ? 16'hFFFF : lat_cnt_q + 16'd1;
                    lat_arm_q <= 1'b0;
                    lat_hit_q <= 1'b1;
                end else if (lat_cnt_q != 16'hFFFF) begin
                    lat_cnt_q <= lat_cnt_q + 16'd1;
                end
            end else if (ar_fire && !lat_hit_q) begin
                lat_arm_q <= 1'b1;
                lat_cnt_q <= '0;
            end
        end
    end

    assign lat_first = lat_q;
`else
    assign lat_first = '0;
`endif

endmodule

// File: tb/tb_hbm_rd_sequencer.sv
// Scoreboard bench for hbm_rd_sequencer: expected AR addresses and run totals are queued at start,
// a negedge monitor pops and compares on every AR handshake and done pulse.

module tb_hbm_rd_sequencer;

    localparam int AW = 33;
    localparam int IW = 6;
    localparam int MO = 32;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [31:0]   cfg_stride = '0, cfg_mask = '0, cfg_num = '0;
    logic [3:0]    cfg_len = '0;
    logic [AW-1:0] araddr;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [IW-1:0] arid;
    logic          arvalid;
    logic          arready = 1'b0;
    logic          rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]    rresp = 2'b00;
    logic          rready, busy, done;
    logic [31:0]   beat_cnt;
    logic [15:0]   err_cnt;
    logic [47:0]   cycle_cnt;
    logic [15:0]   lat_first;

    always #5 clk = ~clk;

    hbm_rd_sequencer #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .arstn(arstn), .start(start),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_mask(cfg_mask),
        .cfg_num(cfg_num), .cfg_len(cfg_len),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rready(rready),
        .busy(busy), .done(done), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
        .cycle_cnt(cycle_cnt), .lat_first(lat_first)
    );

    typedef struct {
        int unsigned num;
        int unsigned beats;
        int unsigned errs;
    } run_exp_t;

    logic [AW-1:0] exp_addr_q[$];
    run_exp_t      done_q[$];
    int unsigned   burst_q[$];
    logic [1:0]    rresp_q[$];

    int   n_cmp = 0, n_bad = 0;
    int   ar_cnt = 0, done_cnt = 0, exp_done = 0, neg_idx = 0;
    int   n_start = 0, n_ar1 = 0, n_r1 = 0;
    bit   ar1_seen = 0, r1_seen = 0;
    bit   r_hold = 0, r_eager = 0, ar_rand = 0, ar_low = 0, r_fire_pend = 0;
    bit   stall_pend = 0;
    logic [AW-1:0] stall_addr = '0;
    logic [3:0]    cur_len = '0;
    int unsigned   cur_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle what the next rising edge will capture.
    always @(negedge clk) begin
        run_exp_t e;
        int       exp_lat;
        neg_idx++;
        if (!arstn) begin
            stall_pend = 0;
        end else begin
            if (stall_pend) begin
                check("ar_hold_valid", arvalid, 1);
                check("ar_hold_addr", araddr, stall_addr);
            end
            stall_pend = arvalid && !arready;
            stall_addr = araddr;
            if (start && !busy && !done) begin
                n_start  = neg_idx;
                ar1_seen = 0;
                r1_seen  = 0;
            end
            if (arvalid && arready) begin
                ar_cnt++;
                if (!ar1_seen) begin
                    ar1_seen = 1;
                    n_ar1    = neg_idx;
                end
                check("ar_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) check("araddr", araddr, exp_addr_q.pop_front());
                check("arlen", arlen, cur_len);
                check("ar_consts", {arsize, arburst, 2'(arid)}, {3'b101, 2'b01, 2'b00});
                burst_q.push_back(int'(cur_len) + 1);
            end
            if (rvalid && rready) begin
                if (busy && !r1_seen) begin
                    r1_seen = 1;
                    n_r1    = neg_idx;
                end
                r_fire_pend = 1;
            end
            if (done) begin
                done_cnt++;
                check("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    e = done_q.pop_front();
`ifdef HBM_RD_LAT_MON_EN
                    exp_lat = (ar1_seen && r1_seen) ? ((n_r1 - n_ar1 > 65535) ? 65535 : n_r1 - n_ar1) : 0;
`else
                    exp_lat = 0;
`endif
                    check("beat_cnt", beat_cnt, e.beats);
                    check("err_cnt", err_cnt, e.errs);
                    check("cycle_cnt", cycle_cnt, 64'(neg_idx - n_start - 1));
                    check("lat_first", lat_first, 64'(exp_lat));
                    check("ar_all_issued", exp_addr_q.size(), 0);
                    if (e.num == 0) check("num0_done_delay", neg_idx - n_start, 1);
                end
            end
        end
    end

    // R responder: returns queued bursts in order, keeps rvalid up until taken.
    always @(posedge clk) begin
        #1;
        if (!arstn) begin
            rvalid = 0; rlast = 0; rresp = 0; cur_left = 0; r_fire_pend = 0;
        end else begin
            if (r_fire_pend) begin
                r_fire_pend = 0;
                if (rresp_q.size() != 0) void'(rresp_q.pop_front());
                if (cur_left != 0) cur_left--;
                rvalid = 0;
            end
            if (!rvalid) begin
                if (cur_left == 0 && burst_q.size() != 0) cur_left = burst_q.pop_front();
                if (cur_left != 0 && !r_hold && (r_eager || $urandom_range(3) != 0)) begin
                    rvalid = 1;
                    rlast  = (cur_left == 1);
                    rresp  = (rresp_q.size() != 0) ? rresp_q[0] : 2'b00;
                end else begin
                    rlast = 0;
                    rresp = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        arready = ar_low ? 1'b0 : (ar_rand ? ($urandom_range(1) == 1) : 1'b1);
    end

    task automatic apply_reset();
        arstn = 1'b0;
        #1;
        check("rst_arvalid", arvalid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_rready", rready, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_beat_err", {beat_cnt, err_cnt}, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_lat_first", lat_first, 0);
        exp_addr_q.delete(); done_q.delete(); burst_q.delete(); rresp_q.delete();
        r_hold = 0; r_eager = 0; ar_low = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        check("rready_up", rready, 1);
    endtask

    // err_idx: -2 no errors, -1 random errors, >=0 that beat index gets SLVERR.
    task automatic start_run(input logic [AW-1:0] base, input logic [31:0] stride, input logic [31:0] mask,
                             input logic [31:0] num, input logic [3:0] len, input int err_idx);
        run_exp_t    e;
        logic [63:0] a;
        logic [31:0] off;
        logic [1:0]  r;
        e.num   = num;
        e.beats = num * (int'(len) + 1);
        e.errs  = 0;
        for (int unsigned k = 0; k < num; k++) begin
            off = 32'(64'(k) * 64'(stride));
            a   = 64'(base) + 64'(off & mask);
            exp_addr_q.push_back(a[AW-1:0]);
        end
        for (int b = 0; b < int'(e.beats); b++) begin
            if (err_idx == -1)     r = ($urandom_range(7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            else if (err_idx == b) r = 2'b10;
            else                   r = 2'b00;
            if (r != 2'b00) e.errs++;
            rresp_q.push_back(r);
        end
        done_q.push_back(e);
        cur_len  = len;
        exp_done = done_cnt + 1;
        @(posedge clk);
        #1;
        cfg_base = base; cfg_stride = stride; cfg_mask = mask; cfg_num = num; cfg_len = len;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt >= exp_done) break;
        end
        check("done_seen", done_cnt >= exp_done, 1);
        if (done_cnt < exp_done) begin
            apply_reset();
        end else begin
            repeat (3) @(posedge clk);
            check("done_once", done_cnt, exp_done);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        logic [AW-1:0] rb;
        logic [31:0] rs, rm, rn;
        int          sh;

        apply_reset();

        start_run(33'h1000, 32'h40, 32'hFFF, 4, 4'd1, -2);
        wait_done(500);

        start_run(33'h2000, 32'h40, 32'hFFF, 0, 4'd3, -2);
        wait_done(50);

        start_run(33'h0, 32'h400, 32'h7FF, 4, 4'd0, -2);
        wait_done(500);

        ar_low = 1;
        start_run(33'h1_0000_0000, 32'h20, 32'hFFFF, 2, 4'd1, 1);
        repeat (5) @(posedge clk);
        ar_low = 0;
        wait_done(500);

        start_run(33'h1_2340_0000, 32'h100, 32'hFFFF_FFFF, 8, 4'd2, -1);
        repeat (4) @(posedge clk);
        #1;
        cfg_base = 33'h0_DEAD_0000; cfg_num = 1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2000);

        r_hold = 1;
        c0 = ar_cnt;
        start_run(33'h4000, 32'h40, 32'hF_FFFF, 40, 4'd0, -2);
        repeat (80) @(posedge clk);
        @(negedge clk);
        #2;
        check("ar_cap_count", ar_cnt - c0, MO);
        check("ar_cap_valid", arvalid, 0);
        check("ar_cap_busy", busy, 1);
        r_hold = 0;
        wait_done(2000);

        r_hold = 1;
        c0 = ar_cnt;
        start_run(33'h8000, 32'h0, 32'h0, 1, 4'd0, -2);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (ar_cnt != c0) break;
        end
        repeat (11) @(posedge clk);
        r_eager = 1;
        r_hold  = 0;
        wait_done(200);
        r_eager = 0;
        #1;
`ifdef HBM_RD_LAT_MON_EN
        check("lat_first_12", lat_first, 12);
`else
        check("lat_first_off", lat_first, 0);
`endif

        ar_rand = 1;
        for (int r = 0; r < 8; r++) begin
            rb = {1'($urandom_range(1)), 32'($urandom)};
            rs = ($urandom_range(1) == 1) ? 32'($urandom_range(0, 64) << 5) : 32'($urandom);
            sh = $urandom_range(4, 32);
            rm = 32'((64'd1 << sh) - 64'd1);
            rn = 32'($urandom_range(1, 50));
            start_run(rb, rs, rm, rn, 4'($urandom_range(15)), -1);
            wait_done(20000);
        end
        ar_rand = 0;

        r_hold = 1;
        c0 = ar_cnt;
        start_run(33'h6000, 32'h80, 32'hFFFF, 4, 4'd3, -2);
        for (int i = 0; i < 50; i++) begin
            if (ar_cnt - c0 >= 4) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_busy", busy, 1);
        check("drain_cycles_running", cycle_cnt != 0, 1);
        #2;
        apply_reset();

        start_run(33'h1000, 32'h40, 32'hFFF, 4, 4'd1, -2);
        wait_done(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
